// File: rtl/ean13_line_decoder_if.sv
// Pixel-row input and decoded-code output bundle for the EAN-13 line decoder.
interface ean13_line_decoder_if;
    logic             line_start;
    logic             pix_valid;
    logic             pix_bit;
    logic             line_end;
    logic [12:0][3:0] scan_data;
    logic             code_valid;
    logic             code_err;
    logic [1:0]       err_code;

    modport master (
        output line_start, pix_valid, pix_bit, line_end,
        input  scan_data, code_valid, code_err, err_code
    );

    modport slave (
        input  line_start, pix_valid, pix_bit, line_end,
        output scan_data, code_valid, code_err, err_code
    );
endinterface

// File: rtl/ean13_line_decoder.sv
// Decodes one rendered EAN-13 pixel row into 13 BCD digits with guard,
// pattern, parity and checksum verification.
module ean13_line_decoder #(
    parameter int unsigned MODULE_W = 4,
    parameter int unsigned LINE_W   = 480
) (
    input  logic               clk,
    input  logic               rst,
    ean13_line_decoder_if.slave bus
);
    localparam int unsigned PIX_W = $clog2(LINE_W);
    localparam int unsigned HALF  = MODULE_W / 2;

    typedef enum logic [2:0] {IDLE, SEEK, SAMPLE, DECODE, CHECK} state_t;

    state_t            state, state_nxt;
    logic [PIX_W-1:0]  pix_cnt;
    logic [6:0]        mod_idx;
    logic [94:0]       mods;       // module m lives at bit 94-m
    logic [3:0]        dig_idx;
    logic              chk_ph;
    logic [7:0]        sum;
    logic [5:0]        parity;     // leftmost digit ends in the MSB, G = 1
    logic              pat_err;
    logic [11:0][3:0]  dig;        // dig[k] becomes scan_data[k+1]
    logic [3:0]        first_dig;
    logic              first_ok;

    logic              seek_hit_c, sample_hit_c, last_cap_c, short_c, guard_ok_c;
    logic [6:0]        dec_base;
    logic [6:0]        dec_pat;
    logic [6:0]        lc;
    logic [3:0]        dec_val;
    logic              dec_par, dec_hit;
    logic [3:0]        first_c;
    logic              first_hit_c;
    logic              valid_nxt, err_nxt, load_nxt;
    logic [1:0]        code_nxt;

    function automatic logic [6:0] l_code(input logic [3:0] v);
        case (v)
            4'd0:    l_code = 7'b0001101;
            4'd1:    l_code = 7'b0011001;
            4'd2:    l_code = 7'b0010011;
            4'd3:    l_code = 7'b0111101;
            4'd4:    l_code = 7'b0100011;
            4'd5:    l_code = 7'b0110001;
            4'd6:    l_code = 7'b0101111;
            4'd7:    l_code = 7'b0111011;
            4'd8:    l_code = 7'b0110111;
            default: l_code = 7'b0001011;
        endcase
    endfunction

    function automatic logic [6:0] rev7(input logic [6:0] x);
        for (int i = 0; i < 7; i++) rev7[i] = x[6-i];
    endfunction

    assign seek_hit_c   = (state == SEEK) && bus.pix_valid && bus.pix_bit;
    assign sample_hit_c = (state == SAMPLE) && bus.pix_valid && (pix_cnt == PIX_W'(HALF));
    assign last_cap_c   = sample_hit_c && (mod_idx == 7'd94);
    assign short_c      = bus.line_end && !bus.line_start &&
                          ((state == SEEK) || ((state == SAMPLE) && !last_cap_c));
    assign guard_ok_c   = (mods[94:92] == 3'b101) && (mods[49:45] == 5'b01010) &&
                          (mods[2:0] == 3'b101);

    // Match the current 7-module digit window against the L/G (left) or R (right) sets.
    always_comb begin
        dec_base = (dig_idx < 4'd6) ? 7'(91 - 7 * int'(dig_idx)) : 7'(86 - 7 * int'(dig_idx));
        dec_pat  = mods[dec_base -: 7];
        lc       = '0;
        dec_val  = '0;
        dec_par  = 1'b0;
        dec_hit  = 1'b0;
        for (int v = 0; v < 10; v++) begin
            lc = l_code(4'(v));
            if (dig_idx < 4'd6) begin
                if (dec_pat == lc) begin
                    dec_val = 4'(v); dec_par = 1'b0; dec_hit = 1'b1;
                end else if (dec_pat == rev7(~lc)) begin
                    dec_val = 4'(v); dec_par = 1'b1; dec_hit = 1'b1;
                end
            end else if (dec_pat == ~lc) begin
                dec_val = 4'(v); dec_hit = 1'b1;
            end
        end
    end

    // First digit recovered from the left-half L/G parity pattern.
    always_comb begin
        first_c     = '0;
        first_hit_c = 1'b1;
        case (parity)
            6'b000000: first_c = 4'd0;
            6'b001011: first_c = 4'd1;
            6'b001101: first_c = 4'd2;
            6'b001110: first_c = 4'd3;
            6'b010011: first_c = 4'd4;
            6'b011001: first_c = 4'd5;
            6'b011100: first_c = 4'd6;
            6'b010101: first_c = 4'd7;
            6'b010110: first_c = 4'd8;
            6'b011010: first_c = 4'd9;
            default:   first_hit_c = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; line_start restarts from any state.
    always_comb begin
        state_nxt = state;
        if (bus.line_start) begin
            state_nxt = SEEK;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                SEEK:    if (bus.line_end) state_nxt = IDLE;
                         else if (seek_hit_c) state_nxt = SAMPLE;
                SAMPLE:  if (last_cap_c) state_nxt = DECODE;
                         else if (bus.line_end) state_nxt = IDLE;
                DECODE:  if (dig_idx == 4'd11) state_nxt = CHECK;
                CHECK:   if (chk_ph) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Verdict for the current line; error priority guard > pattern/parity > checksum.
    always_comb begin
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        load_nxt  = 1'b0;
        code_nxt  = bus.err_code;
        if (short_c) begin
            err_nxt  = 1'b1;
            code_nxt = 2'd0;
        end else if (!bus.line_start && (state == CHECK) && chk_ph) begin
            if (!guard_ok_c) begin
                err_nxt  = 1'b1;
                code_nxt = 2'd1;
            end else if (pat_err || !first_ok) begin
                err_nxt  = 1'b1;
                code_nxt = 2'd2;
            end else if (((sum + 8'(dig[11])) % 8'd10) != 8'd0) begin
                err_nxt  = 1'b1;
                code_nxt = 2'd3;
            end else begin
                valid_nxt = 1'b1;
                load_nxt  = 1'b1;
            end
        end
    end

    // Pixel sampling, digit decode and running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt   <= '0;
            mod_idx   <= '0;
            mods      <= '0;
            dig_idx   <= '0;
            chk_ph    <= 1'b0;
            sum       <= '0;
            parity    <= '0;
            pat_err   <= 1'b0;
            dig       <= '0;
            first_dig <= '0;
            first_ok  <= 1'b0;
        end else if (bus.line_start) begin
            pix_cnt <= '0;
            mod_idx <= '0;
            dig_idx <= '0;
            chk_ph  <= 1'b0;
            sum     <= '0;
            parity  <= '0;
            pat_err <= 1'b0;
        end else begin
            case (state)
                SEEK: if (seek_hit_c) begin
                    pix_cnt <= PIX_W'(1);
                    mod_idx <= '0;
                end
                SAMPLE: if (bus.pix_valid) begin
                    pix_cnt <= (pix_cnt == PIX_W'(MODULE_W - 1)) ? '0 : pix_cnt + PIX_W'(1);
                    if (sample_hit_c) begin
                        mods    <= {mods[93:0], bus.pix_bit};
                        mod_idx <= mod_idx + 7'd1;
                    end
                end
                DECODE: begin
                    dig[dig_idx] <= dec_val;
                    if (!dec_hit) pat_err <= 1'b1;
                    if (dig_idx < 4'd6) parity <= {parity[4:0], dec_par};
                    if (dig_idx != 4'd11) begin
                        sum     <= sum + (dig_idx[0] ? 8'(dec_val) : 8'(dec_val) * 8'd3);
                        dig_idx <= dig_idx + 4'd1;
                    end
                end
                CHECK: if (!chk_ph) begin
                    chk_ph    <= 1'b1;
                    first_dig <= first_c;
                    first_ok  <= first_hit_c;
                    sum       <= sum + 8'(first_c);
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; scan_data only changes together with code_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.scan_data  <= '0;
            bus.code_valid <= 1'b0;
            bus.code_err   <= 1'b0;
            bus.err_code   <= 2'd0;
        end else begin
            bus.code_valid <= valid_nxt;
            bus.code_err   <= err_nxt;
            bus.err_code   <= code_nxt;
            if (load_nxt) bus.scan_data <= {dig, first_dig};
        end
    end
endmodule

// File: tb/tb_ean13_line_decoder.sv
// Randomized pixel-row bench for ean13_line_decoder with a string-level EAN-13 model.
module tb_ean13_line_decoder;
    localparam int MW   = 4;
    localparam int HALF = MW / 2;
    localparam byte ONE  = 8'h31;
    localparam byte ZERO = 8'h30;
    localparam byte GCH  = 8'h47;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [51:0] model_data = '0;

    typedef struct {
        int          c;
        bit          v;
        bit          e;
        logic [1:0]  code;
        logic [51:0] data;
    } ev_t;
    ev_t evq[$];

    string L_STR[10] = '{"0001101", "0011001", "0010011", "0111101", "0100011",
                         "0110001", "0101111", "0111011", "0110111", "0001011"};
    string PARS[10]  = '{"LLLLLL", "LLGLGG", "LLGGLG", "LLGGGL", "LGLLGG",
                         "LGGLLG", "LGGGLL", "LGLGLG", "LGLGGL", "LGGLGL"};

    ean13_line_decoder_if bus();

    ean13_line_decoder #(.MODULE_W(MW), .LINE_W(480)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (bus.code_valid || bus.code_err)
            evq.push_back('{cyc, bus.code_valid, bus.code_err, bus.err_code, bus.scan_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string r_str(input int n);
        string s = L_STR[n];
        for (int j = 0; j < 7; j++) s.putc(j, (L_STR[n][j] == ONE) ? ZERO : ONE);
        return s;
    endfunction

    function automatic string g_str(input int n);
        string r = r_str(n);
        string g = r;
        for (int j = 0; j < 7; j++) g.putc(j, r[6-j]);
        return g;
    endfunction

    function automatic int check_digit(input int dg[13]);
        int s = 0;
        for (int i = 0; i < 12; i++) s += dg[i] * ((i % 2) ? 3 : 1);
        return (10 - s % 10) % 10;
    endfunction

    function automatic string render(input int dg[13]);
        string row = "101";
        for (int i = 1; i <= 6; i++)
            row = {row, (PARS[dg[0]][i-1] == GCH) ? g_str(dg[i]) : L_STR[dg[i]]};
        row = {row, "01010"};
        for (int i = 7; i <= 12; i++) row = {row, r_str(dg[i])};
        row = {row, "101"};
        return row;
    endfunction

    function automatic void parse(input string s, output int dg[13]);
        for (int i = 0; i < 13; i++) dg[i] = int'(s[i]) - 48;
    endfunction

    // Reference: read the row as text, look digits up by pattern, then apply the rules.
    function automatic void ref_model(input string row, output bit ok, output int ec,
                                      output logic [51:0] data);
        int dg[13];
        string par = "";
        string seg;
        bit bad = 1'b0;
        bit hit, hitf = 1'b0;
        int st;
        ok = 1'b0; ec = 0; data = '0;
        for (int i = 0; i < 13; i++) dg[i] = 0;
        for (int k = 0; k < 12; k++) begin
            st  = (k < 6) ? 3 + 7 * k : 50 + 7 * (k - 6);
            seg = row.substr(st, st + 6);
            hit = 1'b0;
            for (int n = 0; n < 10; n++) begin
                if (k < 6) begin
                    if (seg == L_STR[n]) begin dg[k+1] = n; par = {par, "L"}; hit = 1'b1; end
                    else if (seg == g_str(n)) begin dg[k+1] = n; par = {par, "G"}; hit = 1'b1; end
                end else if (seg == r_str(n)) begin
                    dg[k+1] = n; hit = 1'b1;
                end
            end
            if (!hit) bad = 1'b1;
        end
        for (int n = 0; n < 10; n++) if (par == PARS[n]) begin dg[0] = n; hitf = 1'b1; end
        if (row.substr(0, 2) != "101" || row.substr(45, 49) != "01010" || row.substr(92, 94) != "101")
            ec = 1;
        else if (bad || !hitf)
            ec = 2;
        else if (dg[12] != check_digit(dg))
            ec = 3;
        else
            ok = 1'b1;
        for (int i = 0; i < 13; i++) data[4*i +: 4] = 4'(dg[i]);
    endfunction

    task automatic start_line();
        @(negedge clk);
        bus.line_start = 1'b1; bus.line_end = 1'b0; bus.pix_valid = 1'b0; bus.pix_bit = 1'b0;
    endtask

    task automatic drive_px(input bit b, input int gm);
        if (gm == 1 || (gm == 2 && $urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            bus.line_start = 1'b0; bus.line_end = 1'b0;
            bus.pix_valid = 1'b0; bus.pix_bit = 1'($urandom);
        end
        @(negedge clk);
        bus.line_start = 1'b0; bus.line_end = 1'b0;
        bus.pix_valid = 1'b1; bus.pix_bit = b;
    endtask

    task automatic drive_modules(input string row, input int n, input int gm, output int cap);
        cap = -1;
        for (int m = 0; m < n; m++)
            for (int p = 0; p < MW; p++) begin
                drive_px(row[m] == ONE, gm);
                if (m == 94 && p == HALF) cap = cyc + 1;
            end
    endtask

    task automatic finish_line(input int exp_cyc, input bit ok, input int ec, input logic [51:0] nd);
        while (cyc < exp_cyc + 3) begin
            @(negedge clk);
            bus.line_start = 1'b0; bus.line_end = 1'b0; bus.pix_valid = 1'b0;
        end
        if (ok) model_data = nd;
        check("pulse_count", 64'(evq.size()), 64'd1);
        if (evq.size() > 0) begin
            check("latency", 64'(evq[0].c), 64'(exp_cyc));
            check("code_valid", 64'(evq[0].v), 64'(ok));
            check("code_err", 64'(evq[0].e), 64'(!ok));
            if (!ok) check("err_code", 64'(evq[0].code), 64'(ec));
            check("scan_data", 64'(evq[0].data), 64'(model_data));
        end
        evq.delete();
    endtask

    task automatic run_row(input string row, input int gm, input int lead);
        int cap;
        bit ok;
        int ec;
        logic [51:0] nd;
        start_line();
        repeat (lead) drive_px(1'b0, gm);
        drive_modules(row, 95, gm, cap);
        repeat ($urandom_range(0, 3)) drive_px(1'b0, gm);
        @(negedge clk);
        bus.pix_valid = 1'b0; bus.line_end = 1'b1;
        ref_model(row, ok, ec, nd);
        finish_line(cap + 14, ok, ec, nd);
    endtask

    initial begin
        int dg[13];
        string row, good;
        int cap, le, k, kind, pos;
        bus.line_start = 1'b0; bus.line_end = 1'b0; bus.pix_valid = 1'b0; bus.pix_bit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scan_data", 64'(bus.scan_data), 64'd0);
        check("rst_code_valid", 64'(bus.code_valid), 64'd0);
        check("rst_code_err", 64'(bus.code_err), 64'd0);
        check("rst_err_code", 64'(bus.err_code), 64'd0);
        rst = 1'b0;

        parse("6901234567892", dg);
        good = render(dg);
        run_row(good, 0, 8);
        run_row(good, 1, 8);

        parse("6901234567893", dg);
        run_row(render(dg), 0, 5);

        row = good;
        row.putc(47, (row[47] == ONE) ? ZERO : ONE);
        run_row(row, 0, 3);

        row = good;
        for (int j = 17; j < 24; j++) row.putc(j, ONE);
        run_row(row, 2, 3);

        // Short line: end after 60 modules.
        start_line();
        drive_modules(good, 60, 0, cap);
        @(negedge clk);
        bus.pix_valid = 1'b0; bus.line_end = 1'b1;
        le = cyc + 1;
        finish_line(le, 1'b0, 0, model_data);

        // Abort at module 40, then a complete different row.
        parse("4006381333931", dg);
        row = render(dg);
        start_line();
        drive_modules(row, 40, 0, cap);
        run_row(row, 0, 4);

        // Randomized rows with assorted corruptions.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 12; i++) dg[i] = $urandom_range(0, 9);
            dg[12] = check_digit(dg);
            kind = $urandom_range(0, 3);
            if (kind == 1) dg[12] = (dg[12] + $urandom_range(1, 9)) % 10;
            row = render(dg);
            if (kind == 2) begin
                pos = $urandom_range(1, 94);
                row.putc(pos, (row[pos] == ONE) ? ZERO : ONE);
            end else if (kind == 3) begin
                k   = $urandom_range(0, 11);
                pos = (k < 6) ? 3 + 7 * k : 50 + 7 * (k - 6);
                for (int j = 0; j < 7; j++) row.putc(pos + j, $urandom_range(0, 1) ? ONE : ZERO);
            end
            run_row(row, $urandom_range(0, 2), $urandom_range(0, 12));
        end

        // Reset in the middle of sampling.
        start_line();
        drive_modules(good, 30, 0, cap);
        @(negedge clk);
        rst = 1'b1; bus.pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_scan_data", 64'(bus.scan_data), 64'd0);
        check("midrst_code_valid", 64'(bus.code_valid), 64'd0);
        check("midrst_code_err", 64'(bus.code_err), 64'd0);
        rst = 1'b0;
        model_data = '0;
        repeat (20) @(negedge clk);
        check("midrst_no_pulse", 64'(evq.size()), 64'd0);
        evq.delete();
        run_row(good, 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
